// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and parameter legality check for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic bit width_ok(input int width, input int chunk);
    return chunk >= 1 && width >= 2 && width % chunk == 0;
  endfunction
endpackage

// File: rtl/fa_chunk.sv
// fa_chunk: combinational N-bit ripple slice; a,b,cin in; s, cout, c_msb (carry into top bit) out
module fa_chunk #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign c_msb = s[N-1] ^ a[N-1] ^ b[N-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/sub, CHUNK bits per clock; start/busy/done handshake, sum/c_out/overflow results
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW = $clog2(STEPS + 1);
  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_c, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK-1:0] w_s;
  logic             w_cout, w_cmsb, w_last;
  fa_chunk #(.N(CHUNK)) u_fa (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout),
    .c_msb(w_cmsb)
  );
  assign w_last = r_cnt == CW'(STEPS - 1);
  always_comb begin
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    busy   = r_state == RUN;
    done   = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != RUN && start) begin
        r_a   <= in_a;
        r_b   <= sub ? ~in_b : in_b;
        r_c   <= c_in ^ sub;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_sum <= (r_sum >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));
        r_a   <= r_a >> CHUNK;
        r_b   <= r_b >> CHUNK;
        r_c   <= w_cout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_cout <= w_cout;
          r_ovf  <= w_cmsb ^ w_cout;
        end
      end
    end
  end
  assign sum      = r_sum;
  assign c_out    = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: three configurations (8/1, 8/4, 4/2) checked against an arithmetic model plus literal vectors
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic       st[3], ci[3], sb[3];
  logic [7:0] ia[3], ib[3];
  logic       bz[3], dn[3], co[3], ov[3];
  logic [7:0] s0, s1;
  logic [3:0] s2;
  int W[3]  = '{8, 8, 4};
  int ST[3] = '{8, 2, 2};
  int errs = 0, checks = 0;
  int rem[3];
  logic done_e[3];
  logic [9:0] pend[3], res[3];
  serial_adder #(.WIDTH(8), .CHUNK(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .in_a(ia[0]), .in_b(ib[0]), .c_in(ci[0]), .sub(sb[0]),
    .busy(bz[0]), .done(dn[0]), .sum(s0), .c_out(co[0]), .overflow(ov[0]));
  serial_adder #(.WIDTH(8), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .in_a(ia[1]), .in_b(ib[1]), .c_in(ci[1]), .sub(sb[1]),
    .busy(bz[1]), .done(dn[1]), .sum(s1), .c_out(co[1]), .overflow(ov[1]));
  serial_adder #(.WIDTH(4), .CHUNK(2)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .in_a(ia[2][3:0]), .in_b(ib[2][3:0]), .c_in(ci[2]), .sub(sb[2]),
    .busy(bz[2]), .done(dn[2]), .sum(s2), .c_out(co[2]), .overflow(ov[2]));
  function automatic logic [7:0] sum_of(input int k);
    return k == 0 ? s0 : k == 1 ? s1 : {4'b0, s2};
  endfunction
  function automatic logic [9:0] calc(input int w, input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    int m, ua, ub, cv, r, sa, sbv, sr;
    logic cy, vf;
    m   = 1 << w;
    ua  = int'(a) & (m - 1);
    ub  = int'(b) & (m - 1);
    cv  = c ? 1 : 0;
    r   = s ? ua - ub - cv : ua + ub + cv;
    cy  = s ? (ua >= ub + cv) : (r >= m);
    sa  = ua >= m / 2 ? ua - m : ua;
    sbv = ub >= m / 2 ? ub - m : ub;
    sr  = s ? sa - sbv - cv : sa + sbv + cv;
    vf  = sr < -(m / 2) || sr >= m / 2;
    return {vf, cy, 8'(r & (m - 1))};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rem[k] <= 0;
        done_e[k] <= 1'b0;
        res[k] <= '0;
      end else if (rem[k] > 0) begin
        rem[k] <= rem[k] - 1;
        done_e[k] <= rem[k] == 1;
        if (rem[k] == 1) res[k] <= pend[k];
      end else begin
        done_e[k] <= 1'b0;
        if (st[k]) begin
          pend[k] <= calc(W[k], ia[k], ib[k], ci[k], sb[k]);
          rem[k] <= ST[k];
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy[%0d]", k), bz[k], rem[k] > 0);
      chk($sformatf("done[%0d]", k), dn[k], done_e[k]);
      if (done_e[k]) chk($sformatf("result[%0d] {ovf,cout,sum}", k), {ov[k], co[k], sum_of(k)}, res[k]);
    end
  end
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input bit lit, input logic [7:0] es, input logic ec, input logic eo,
                        input bit scramble, input bit pulse);
    int n, nb;
    @(negedge clk);
    ia[k] = a; ib[k] = b; ci[k] = c; sb[k] = s; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    if (scramble) begin
      ia[k] = ~a; ib[k] = ~b; ci[k] = ~c; sb[k] = ~s;
    end
    n = 0;
    nb = 0;
    while (dn[k] !== 1'b1 && n < 64) begin
      if (bz[k] === 1'b1) nb++;
      st[k] = pulse && n == 1;
      @(negedge clk);
      n++;
    end
    st[k] = 1'b0;
    chk($sformatf("latency[%0d]", k), n, ST[k]);
    chk($sformatf("busy_cycles[%0d]", k), nb, ST[k]);
    if (lit) begin
      chk($sformatf("lit_sum[%0d] %0h/%0h", k, a, b), sum_of(k), es);
      chk($sformatf("lit_cout[%0d] %0h/%0h", k, a, b), co[k], ec);
      chk($sformatf("lit_ovf[%0d] %0h/%0h", k, a, b), ov[k], eo);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; ia[k] = '0; ib[k] = '0; ci[k] = 1'b0; sb[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy[%0d]", k), bz[k], 0);
      chk($sformatf("reset_done[%0d]", k), dn[k], 0);
      chk($sformatf("reset_sum[%0d]", k), sum_of(k), 0);
      chk($sformatf("reset_cout[%0d]", k), co[k], 0);
      chk($sformatf("reset_ovf[%0d]", k), ov[k], 0);
    end
    rst = 1'b0;
    run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 1, 8'h8D, 1'b0, 1'b1, 1, 1);
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 1, 8'hF0, 1'b0, 1'b0, 0, 0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1, 8'h7F, 1'b1, 1'b1, 1, 0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1, 8'h80, 1'b0, 1'b1, 0, 0);
    run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, 1, 8'h01, 1'b1, 1'b0, 1, 1);
    @(negedge clk);
    ia[1] = 8'h12; ib[1] = 8'h34; ci[1] = 1'b0; sb[1] = 1'b0; st[1] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_done i=%0d", i), dn[1], i % 3 == 0);
      if (dn[1]) chk("b2b_sum", s1, 8'h46);
    end
    st[1] = 1'b0;
    @(negedge clk);
    ia[0] = 8'h5A; ib[0] = 8'h33; ci[0] = 1'b0; sb[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bz[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_sum", s0, 0);
    chk("abort_cout", co[0], 0);
    chk("abort_ovf", ov[0], 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", dn[0], 0);
    end
    run_op(0, 8'h80, 8'h80, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b1, 0, 0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            run_op(2, 8'(a), 8'(b), c == 1, s == 1, 0, 8'h0, 1'b0, 1'b0, a % 2 == 1, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised digit-serial adder/subtractor. Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using a CHUNK-bit full-adder slice and a carry flip-flop.
- Next generation of the lab's 1-bit full adder: configurable width, digit size, subtract mode, signed overflow, and a start/busy/done handshake.
- Sits as an arithmetic leaf under lab-level controllers and benches.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 1, bits processed per clock. Must be ≥ 1 and divide WIDTH.
- STEPS (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is not busy.
- in_a  in  WIDTH  operand A (unsigned or two's complement).
- in_b  in  WIDTH  operand B.
- c_in  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = A+B+c_in; 1 = A−B−c_in.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out. For subtract, 1 = no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock. Reset is synchronous and active-high; port names are clk and rst.
- Reset: state IDLE. busy=0, done=0, sum=0, c_out=0, overflow=0. Internal shift registers, step counter and carry flip-flop are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on a clock edge with start=1.
  - Latches A into the A shift register.
  - Latches B into the B shift register, bitwise inverted when sub=1.
  - Carry flip-flop is loaded with c_in XOR sub.
  - sub is latched; later changes to sub have no effect.
  - Step counter = 0.
- RUN: on each edge, the slice adds the low CHUNK bits of A, B and the carry.
  - Result bits shift into sum from the MSB side.
  - A and B shift right by CHUNK.
  - Carry flip-flop takes the slice carry-out.
  - Counter increments.
- RUN → DONE on the edge that processes chunk STEPS−1.
  - c_out is set to that edge's slice carry-out.
  - overflow is set to carry-into-MSB XOR carry-out, captured inside the final slice.
- Latency: done is high in the cycle following the STEPS-th edge after the accepting edge. For WIDTH=8, CHUNK=1 that is 8 edges.
- DONE lasts exactly one cycle with done=1, then returns to IDLE. If start=1 during DONE, the next operation is accepted directly (DONE → RUN, back-to-back).
- busy=1 in RUN only; busy=0 in IDLE and DONE.
- start while busy is ignored. Input changes during RUN are ignored.
- sum, c_out and overflow are valid from the done cycle and hold until the next accepted start.
  - During RUN, sum shows partial shift contents and is undefined for consumers.
  - The bench must check sum only when done=1.
- rst asserted during RUN or DONE aborts on that edge and returns to the reset state. No done pulse is produced.
- Width rule: all arithmetic is modulo 2^WIDTH. There is no sign extension.

Decomposition:
- Shared package/header serial_adder_pkg:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - A width-checking macro/function asserting WIDTH % CHUNK == 0.
- One natural sub-module: fa_chunk, a combinational CHUNK-bit ripple slice.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb (carry into the slice's top bit).
  - c_msb is used for overflow.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, CHUNK=1, sub=0: A=0x5A, B=0x33, c_in=0 → sum=0x8D, c_out=0, overflow=1. done pulses 8 edges after the start edge; busy=1 for exactly 8 cycles.
- WIDTH=8, CHUNK=1, sub=1: A=0x10, B=0x20, c_in=0 → sum=0xF0, c_out=0 (borrow), overflow=0. Then A=0x80, B=0x01 → sum=0x7F, c_out=1, overflow=1.
- WIDTH=8, CHUNK=4:
  - A=0x7F, B=0x01 → sum=0x80, overflow=1, done after 2 compute edges.
  - A=0xFF, B=0x01, c_in=1 → sum=0x01, c_out=1, overflow=0.
- Handshake:
  - start held high continuously → back-to-back ops with done every STEPS+1 cycles.
  - Changing in_a/in_b/sub mid-RUN does not alter the result.
  - A start pulse in RUN is ignored.
- Reset: assert rst at step 3 of a WIDTH=8, CHUNK=1 op → next cycle busy=0, done=0, sum=0, c_out=0, overflow=0, and no done pulse follows. A fresh op then completes correctly.
- Exhaustive check, WIDTH=4, CHUNK=2: all A, B, c_in, sub (1024 cases) against a behavioural model for sum, c_out and overflow.
